ov7670_pixel_packer: RTL and testbench
======================================

# ov7670_pixel_packer

Capture-side stage between the OV7670 parallel pixel bus and the frame buffer write port. Samples VSYNC/HREF/D on the camera pixel clock, assembles byte pairs of RGB565 into 12-bit RGB444 words and generates a linear write address and one-cycle write strobe per pixel. Also produces frame-boundary pulses, a frame counter and sticky geometry-error flags for the LED/debug path. Output drives the frame buffer port A (`addra`/`dina`/`wea`) directly.

## Interface
- `H_PIXELS`, 640, pixels per line (2 bytes each)
- `V_LINES`, 480, lines per frame
- `ADDR_W`, 19, write-address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
- `pclk`  in  1  camera pixel clock; all logic on rising edge; sole clock
- `rst`  in  1  asynchronous, active-high reset
- `vsync`  in  1  camera VSYNC, high = vertical blanking
- `href`  in  1  camera HREF, high = active line bytes
- `d`  in  8  camera data bus
- `addr`  out  ADDR_W  frame buffer write address
- `dout`  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- `we`  out  1  write strobe, one cycle per pixel
- `frame_done`  out  1  one-cycle pulse at end of each captured frame
- `frame_count`  out  8  completed-frame counter, wraps 255->0
- `line_err`  out  1  sticky: a line had byte count != 2*H_PIXELS
- `frame_err`  out  1  sticky: a frame had line count != V_LINES or pixel overflow

## Operation
- Input stage: `vsync`, `href`, `d` registered every edge into `vs_r`, `hr_r`, `d_r`; all logic below uses registered copies only.
- FSM states: WAIT_SYNC, WAIT_FRAME, ACTIVE.
  - Reset -> WAIT_SYNC. Data ignored, `we`=0.
  - WAIT_SYNC: on `vs_r`=1 -> WAIT_FRAME (guarantees first capture starts at a clean frame).
  - WAIT_FRAME: on `vs_r` 1->0 -> ACTIVE; pixel index, line count, byte phase cleared to 0.
  - ACTIVE: on `vs_r` 0->1 -> WAIT_FRAME; pulse `frame_done`, increment `frame_count`; if line count != V_LINES set `frame_err`.
- Byte phase toggles on each cycle with `hr_r`=1 in ACTIVE; cleared when `hr_r`=0.
  - Phase 0: `hi` <= `d_r`.
  - Phase 1: `dout` <= {hi[7:4], hi[2:0], d_r[7], d_r[4:1]}; `addr` <= pixel index; `we` <= 1; pixel index += 1.
- Pixel index saturates: when index == H_PIXELS*V_LINES, further pixel completions produce no `we`, index holds, `frame_err` set.
- Line end (`hr_r` 1->0 in ACTIVE): line count += 1; if line byte count != 2*H_PIXELS set `line_err`. Odd trailing byte discarded, no write.
- `href` activity outside ACTIVE ignored; no writes, no error flags.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `addr`=0, `dout`=0, `we`=0, `frame_done`=0, `frame_count`=0, `line_err`=0, `frame_err`=0; FSM WAIT_SYNC.
- Latency: low byte on pins at edge T -> `we`=1, `dout`, `addr` valid after edge T+1 for exactly one cycle (deasserted after T+2).
- `addr`/`dout` hold last values while `we`=0.
- `frame_done` high for the one cycle after edge T+1, where T is the edge sampling `vsync` rising during ACTIVE.
- Pixel completing at the same edge as `vs_r` rises: the write still occurs, then the frame closes.
- `href` falling and `vsync` rising on the same edge: line end processed first (line count includes that line), then the frame check.
- `rst` asserted mid-frame: all outputs return to reset values immediately; next capture waits for a full vsync high->low.

## Test plan
- Reset: assert `rst` mid-line -> all outputs 0 asynchronously; with `vsync` held low after release, no `we` ever.
- Basic frame (H_PIXELS=4, V_LINES=2): vsync pulse, two lines of 8 bytes, first pair 0xF8,0x1F -> `dout`=0xF0F, `addr` 0..7 with 8 `we` pulses, each 2 edges after its low byte; `frame_done` one pulse, `frame_count`=1, flags 0.
- Short line: 6 bytes on line 1 -> 3 writes for that line, `line_err`=1, `frame_err`=0 if line count matches.
- Odd bytes: 7 bytes -> 3 writes, trailing byte dropped, `line_err`=1.
- Overflow: 3 full lines with V_LINES=2 -> writes stop at `addr`=7, `frame_err`=1, `frame_done` at vsync rise.
- Wrap: 256 frames -> `frame_count` returns to 0; first frame after reset with data before any vsync produces no writes.

Source files
------------

// File: rtl/ov7670_pixel_packer.sv
// ov7670_pixel_packer: packs OV7670 RGB565 byte pairs into RGB444 frame-buffer writes with frame and geometry status
module ov7670_pixel_packer #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_err,
    output logic              frame_err
);
    localparam int BW = $clog2(2 * H_PIXELS + 1) + 1;
    localparam int LW = $clog2(V_LINES + 1) + 1;
    localparam logic [ADDR_W:0] NPIX  = (ADDR_W + 1)'(H_PIXELS * V_LINES);
    localparam logic [BW-1:0]   NBYTE = BW'(2 * H_PIXELS);
    localparam logic [LW-1:0]   NLINE = LW'(V_LINES);
    typedef enum logic [1:0] {WAIT_SYNC, WAIT_FRAME, ACTIVE} state_t;
    state_t state, state_nx;
    logic vs_r, hr_r, vs_p, hr_p, phase;
    logic [7:0] d_r;
    logic [6:0] hi;
    logic [ADDR_W:0] pix;
    logic [BW-1:0] byte_cnt;
    logic [LW-1:0] line_cnt, line_cnt_nx;
    logic active, line_end, pix_done, start, close;
    assign active      = state == ACTIVE;
    assign line_end    = active && hr_p && !hr_r;
    assign pix_done    = active && hr_r && phase;
    assign start       = state == WAIT_FRAME && vs_p && !vs_r;
    assign close       = active && vs_r && !vs_p;
    assign line_cnt_nx = line_cnt + {{(LW-1){1'b0}}, line_end && !(&line_cnt)};
    always_ff @(posedge pclk or posedge rst)
        if (rst) state <= WAIT_SYNC;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = close ? WAIT_FRAME : start ? ACTIVE : (state == WAIT_SYNC && vs_r) ? WAIT_FRAME : state;
    end
    always_ff @(posedge pclk or posedge rst)
        if (rst) begin
            vs_r        <= 1'b0;
            hr_r        <= 1'b0;
            vs_p        <= 1'b0;
            hr_p        <= 1'b0;
            d_r         <= '0;
            hi          <= '0;
            phase       <= 1'b0;
            pix         <= '0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            addr        <= '0;
            dout        <= '0;
            we          <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vs_r       <= vsync;
            hr_r       <= href;
            d_r        <= d;
            vs_p       <= vs_r;
            hr_p       <= hr_r;
            we         <= 1'b0;
            frame_done <= 1'b0;
            phase      <= active && hr_r && !phase;
            byte_cnt   <= (active && hr_r) ? byte_cnt + {{(BW-1){1'b0}}, !(&byte_cnt)} : '0;
            line_cnt   <= line_cnt_nx;
            if (active && hr_r && !phase) hi <= {d_r[7:4], d_r[2:0]};
            // a full frame buffer turns further pixels into an error instead of a write
            if (pix_done && pix == NPIX) frame_err <= 1'b1;
            if (pix_done && pix != NPIX) begin
                dout <= {hi, d_r[7], d_r[4:1]};
                addr <= pix[ADDR_W-1:0];
                we   <= 1'b1;
                pix  <= pix + (ADDR_W + 1)'(1);
            end
            if (line_end && byte_cnt != NBYTE) line_err <= 1'b1;
            if (close) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
                if (line_cnt_nx != NLINE) frame_err <= 1'b1;
            end
            if (start) begin
                pix      <= '0;
                line_cnt <= '0;
            end
        end
endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// tb_ov7670_pixel_packer: scoreboard bench for the OV7670 pixel packer on a 4x2 frame
module tb_ov7670_pixel_packer;
    localparam int H = 4, V = 2, AW = 3;
    logic pclk = 0, rst = 0, vsync = 0, href = 0;
    logic [7:0] d = 0;
    logic [AW-1:0] addr;
    logic [11:0] dout;
    logic we, frame_done, line_err, frame_err;
    logic [7:0] frame_count;
    int vectors = 0, miscompares = 0;
    int edge_cnt = 0, fd_cnt = 0, fd_edge = 0, we_cnt = 0, pidx = 0, vs_t = 0;
    logic cap = 0;
    logic [7:0] hi_b;
    typedef struct {logic [AW-1:0] a; logic [11:0] px; int t;} exp_t;
    exp_t exp_q[$];

    ov7670_pixel_packer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
        .frame_count(frame_count), .line_err(line_err), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) edge_cnt++;

    always @(negedge pclk) begin
        exp_t e;
        if (frame_done) begin
            fd_cnt++;
            fd_edge = edge_cnt;
        end
        if (we) begin
            we_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_we: got addr=%0d dout=%h, required no write", addr, dout);
            end else begin
                e = exp_q.pop_front();
                if (addr !== e.a || dout !== e.px || edge_cnt !== e.t) begin
                    miscompares++;
                    $display("FAIL write: got addr=%0d dout=%h edge=%0d, required addr=%0d dout=%h edge=%0d",
                             addr, dout, edge_cnt, e.a, e.px, e.t);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task cyc(input logic v, input logic h, input logic [7:0] b);
        vsync = v;
        href  = h;
        d     = b;
        @(posedge pclk);
        #1;
    endtask

    task idle(input logic v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0, 8'h00);
    endtask

    task vs_pulse;
        idle(1'b1, 2);
        idle(1'b0, 3);
        pidx = 0;
        cap  = 1'b1;
    endtask

    task frame_end;
        if (!vsync) vs_t = edge_cnt + 2;
        cap = 1'b0;
        idle(1'b1, 3);
    endtask

    task send_line(input int n, input logic [7:0] b0, input logic [7:0] b1, input int gap, input logic vl);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = (i == 0) ? b0 : (i == 1) ? b1 : 8'(b0 + i * 37 + b1);
            if (i % 2 == 0) hi_b = b;
            else if (cap && pidx < H * V) begin
                exp_q.push_back('{a: AW'(pidx), px: {hi_b[7:4], hi_b[2:0], b[7], b[4:1]}, t: edge_cnt + 2});
                pidx++;
            end
            if (i == n - 1 && vl) vs_t = edge_cnt + 2;
            cyc((i == n - 1) ? vl : 1'b0, 1'b1, b);
            if (i == n - 1 && vl) cap = 1'b0;
        end
        for (int i = 0; i < gap; i++) cyc(vsync, 1'b0, 8'h00);
    endtask

    task drain;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge pclk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected writes never appeared, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task do_reset;
        rst   = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        exp_q.delete();
        cap   = 1'b0;
        pidx  = 0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        idle(1'b0, 2);
    endtask

    task test_reset;
        int w0;
        #1 rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        vectors++;
        if ({addr, dout, we, frame_done, frame_count, line_err, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got addr=%0d dout=%h we=%b fd=%b fc=%0d le=%b fe=%b, required all 0",
                     addr, dout, we, frame_done, frame_count, line_err, frame_err);
        end
        rst = 1'b0;
        w0  = we_cnt;
        send_line(8, 8'hF8, 8'h1F, 3, 1'b0);
        send_line(8, 8'h12, 8'h34, 3, 1'b0);
        vectors++;
        if (we_cnt - w0 !== 0 || {line_err, frame_err, frame_count} !== '0) begin
            miscompares++;
            $display("FAIL no_sync_capture: got writes=%0d le=%b fe=%b fc=%0d, required 0/0/0/0",
                     we_cnt - w0, line_err, frame_err, frame_count);
        end
    endtask

    task test_basic_frame;
        int w0, f0;
        do_reset;
        w0 = we_cnt;
        f0 = fd_cnt;
        vs_pulse;
        send_line(8, 8'hF8, 8'h1F, 3, 1'b0);
        send_line(8, 8'hA5, 8'h5A, 3, 1'b0);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 8 || fd_cnt - f0 !== 1 || fd_edge !== vs_t) begin
            miscompares++;
            $display("FAIL basic_counts: got writes=%0d fd=%0d fd_edge=%0d, required 8/1/%0d",
                     we_cnt - w0, fd_cnt - f0, fd_edge, vs_t);
        end
        vectors++;
        if ({frame_count, line_err, frame_err} !== {8'd1, 1'b0, 1'b0} || addr !== 3'd7) begin
            miscompares++;
            $display("FAIL basic_status: got fc=%0d le=%b fe=%b addr=%0d, required 1/0/0/7",
                     frame_count, line_err, frame_err, addr);
        end
    endtask

    task test_short_line;
        int w0;
        do_reset;
        w0 = we_cnt;
        vs_pulse;
        send_line(8, 8'h11, 8'h22, 3, 1'b0);
        send_line(6, 8'hC3, 8'h3C, 3, 1'b0);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 7 || {line_err, frame_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL short_line: got writes=%0d le=%b fe=%b, required 7/1/0", we_cnt - w0, line_err, frame_err);
        end
    endtask

    task test_odd_bytes;
        int w0;
        do_reset;
        w0 = we_cnt;
        vs_pulse;
        send_line(7, 8'h81, 8'h7E, 3, 1'b0);
        send_line(8, 8'h0F, 8'hF0, 3, 1'b0);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 7 || {line_err, frame_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL odd_bytes: got writes=%0d le=%b fe=%b, required 7/1/0", we_cnt - w0, line_err, frame_err);
        end
    endtask

    task test_overflow;
        int w0, f0;
        do_reset;
        w0 = we_cnt;
        f0 = fd_cnt;
        vs_pulse;
        send_line(8, 8'h21, 8'h43, 3, 1'b0);
        send_line(8, 8'h65, 8'h87, 3, 1'b0);
        send_line(8, 8'hA9, 8'hCB, 3, 1'b0);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 8 || addr !== 3'd7 || fd_cnt - f0 !== 1 || {line_err, frame_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL overflow: got writes=%0d addr=%0d fd=%0d le=%b fe=%b, required 8/7/1/0/1",
                     we_cnt - w0, addr, fd_cnt - f0, line_err, frame_err);
        end
    endtask

    task test_boundary_edges;
        int w0;
        do_reset;
        w0 = we_cnt;
        vs_pulse;
        send_line(8, 8'h13, 8'h57, 3, 1'b0);
        send_line(8, 8'h9B, 8'hDF, 0, 1'b0);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 8 || {line_err, frame_err} !== 2'b00 || fd_edge !== vs_t) begin
            miscompares++;
            $display("FAIL href_fall_with_vsync: got writes=%0d le=%b fe=%b fd_edge=%0d, required 8/0/0/%0d",
                     we_cnt - w0, line_err, frame_err, fd_edge, vs_t);
        end
        do_reset;
        w0 = we_cnt;
        vs_pulse;
        send_line(8, 8'h24, 8'h68, 3, 1'b0);
        send_line(8, 8'hAC, 8'hE0, 0, 1'b1);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 8 || {line_err, frame_err, frame_count} !== {2'b01, 8'd1} || fd_edge !== vs_t) begin
            miscompares++;
            $display("FAIL pixel_with_vsync: got writes=%0d le=%b fe=%b fc=%0d fd_edge=%0d, required 8/0/1/1/%0d",
                     we_cnt - w0, line_err, frame_err, frame_count, fd_edge, vs_t);
        end
    endtask

    task test_mid_frame_reset;
        int w0;
        do_reset;
        vs_pulse;
        send_line(6, 8'h5A, 8'hA5, 3, 1'b0);
        send_line(8, 8'h3E, 8'hC1, 0, 1'b0);
        cyc(1'b0, 1'b1, 8'h55);
        #2 rst = 1'b1;
        href = 1'b0;
        exp_q.delete();
        cap = 1'b0;
        #1;
        vectors++;
        if ({addr, dout, we, frame_done, frame_count, line_err, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got addr=%0d dout=%h we=%b fd=%b fc=%0d le=%b fe=%b, required all 0",
                     addr, dout, we, frame_done, frame_count, line_err, frame_err);
        end
        @(posedge pclk);
        #1 rst = 1'b0;
        w0 = we_cnt;
        send_line(8, 8'h77, 8'h88, 3, 1'b0);
        vectors++;
        if (we_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL reset_no_capture: got writes=%0d, required 0", we_cnt - w0);
        end
        vs_pulse;
        send_line(8, 8'h19, 8'h91, 3, 1'b0);
        frame_end;
        drain;
        vectors++;
        if (we_cnt - w0 !== 4 || frame_count !== 8'd1 || line_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_recapture: got writes=%0d fc=%0d le=%b, required 4/1/0", we_cnt - w0, frame_count, line_err);
        end
    endtask

    task test_wrap;
        int w0, f0;
        do_reset;
        w0 = we_cnt;
        f0 = fd_cnt;
        for (int i = 0; i < 255; i++) begin
            vs_pulse;
            frame_end;
        end
        vectors++;
        if (frame_count !== 8'd255) begin
            miscompares++;
            $display("FAIL count_255: got fc=%0d, required 255", frame_count);
        end
        vs_pulse;
        frame_end;
        vectors++;
        if (frame_count !== 8'd0 || fd_cnt - f0 !== 256 || we_cnt - w0 !== 0) begin
            miscompares++;
            $display("FAIL count_wrap: got fc=%0d fd=%0d writes=%0d, required 0/256/0", frame_count, fd_cnt - f0, we_cnt - w0);
        end
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_short_line;
        test_odd_bytes;
        test_overflow;
        test_boundary_edges;
        test_mid_frame_reset;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
